// File: rtl/spi_frame_fsm.sv
// Frame-level control FSM for the SPI memory slave: sequences address capture,
// read load/shift and write commit from conditioned serial-clock edge pulses.
module spi_frame_fsm #(
    parameter int FRAME_BITS = 8,
    parameter int COUNT_W    = 4
) (
    input  logic clk,
    input  logic resetN,
    input  logic chipSelect,
    input  logic sclkPosEdge,
    input  logic sclkNegEdge,
    input  logic rwBit,
    output logic addrWe,
    output logic srWe,
    output logic dmWe,
    output logic misoBufe,
    output logic busy
);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_GET, WRITE_COMMIT, DONE
    } state_t;

    localparam logic [COUNT_W-1:0] LAST = COUNT_W'(FRAME_BITS - 1);

    state_t             state;
    logic [COUNT_W-1:0] count;

    // Outputs are registered alongside the state they belong to, so each
    // output is a pure function of the state register.
    always_ff @(posedge clk) begin
        if (!resetN || chipSelect) begin
            state    <= IDLE;
            count    <= '0;
            addrWe   <= 1'b0;
            srWe     <= 1'b0;
            dmWe     <= 1'b0;
            misoBufe <= 1'b0;
            busy     <= 1'b0;
        end else begin
            addrWe <= 1'b0;
            srWe   <= 1'b0;
            dmWe   <= 1'b0;
            case (state)
                IDLE: begin
                    state <= GET_ADDR;
                    count <= '0;
                    busy  <= 1'b1;
                end
                GET_ADDR: if (sclkPosEdge) begin
                    if (count == LAST) begin
                        state  <= GOT_ADDR;
                        count  <= '0;
                        addrWe <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                GOT_ADDR: begin
                    count <= '0;
                    if (rwBit) begin
                        state    <= READ_LOAD;
                        srWe     <= 1'b1;
                        misoBufe <= 1'b1;
                    end else begin
                        state <= WRITE_GET;
                    end
                end
                READ_LOAD: begin
                    state <= READ_SHIFT;
                    count <= '0;
                end
                // Read data leaves on falling edges; rising edges are ignored here.
                READ_SHIFT: if (sclkNegEdge) begin
                    if (count == LAST) begin
                        state    <= DONE;
                        misoBufe <= 1'b0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                WRITE_GET: if (sclkPosEdge) begin
                    if (count == LAST) begin
                        state <= WRITE_COMMIT;
                        dmWe  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                WRITE_COMMIT: state <= DONE;
                DONE: ;
                default: begin
                    state    <= IDLE;
                    count    <= '0;
                    misoBufe <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_fsm.sv
// Directed self-checking bench for spi_frame_fsm; inputs change and outputs
// are sampled on the falling clk edge.
module tb_spi_frame_fsm;

    logic clk = 1'b0;
    logic resetN, chipSelect, sclkPosEdge, sclkNegEdge, rwBit;
    logic addrWe, srWe, dmWe, misoBufe, busy;

    int n_chk = 0;
    int n_pass = 0;
    int n_addr = 0, n_sr = 0, n_dm = 0, n_multi = 0;

    always #5 clk = ~clk;

    spi_frame_fsm #(.FRAME_BITS(8), .COUNT_W(4)) dut (
        .clk(clk), .resetN(resetN), .chipSelect(chipSelect),
        .sclkPosEdge(sclkPosEdge), .sclkNegEdge(sclkNegEdge), .rwBit(rwBit),
        .addrWe(addrWe), .srWe(srWe), .dmWe(dmWe), .misoBufe(misoBufe), .busy(busy)
    );

    // Pulse-cycle counters; values seen during a clk period are tallied at its end.
    always @(posedge clk) begin
        n_addr  <= n_addr + int'(addrWe);
        n_sr    <= n_sr + int'(srWe);
        n_dm    <= n_dm + int'(dmWe);
        n_multi <= n_multi + int'((int'(addrWe) + int'(srWe) + int'(dmWe)) > 1);
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-clk edge pulse; returns on the negedge after it was sampled.
    task automatic pulse(input bit pos, input bit neg);
        sclkPosEdge = pos;
        sclkNegEdge = neg;
        @(negedge clk);
        sclkPosEdge = 1'b0;
        sclkNegEdge = 1'b0;
    endtask

    // n rising-edge pulses, one every 5 clk; ends on the negedge right after the last.
    task automatic pos_edges(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(1'b1, 1'b0);
            if (i != n - 1) idle(4);
        end
    endtask

    task automatic neg_edges(input int n);
        for (int i = 0; i < n; i++) begin
            pulse(1'b0, 1'b1);
            if (i != n - 1) idle(4);
        end
    endtask

    task automatic end_frame();
        chipSelect = 1'b1;
        idle(2);
    endtask

    int a0, s0, d0;

    initial begin
        resetN = 1'b0; chipSelect = 1'b0; sclkPosEdge = 1'b0; sclkNegEdge = 1'b0; rwBit = 1'b0;

        // Reset held with chip select low and edges toggling
        @(negedge clk);
        pulse(1'b1, 1'b1);
        chk("rst_busy", busy, 0);
        chk("rst_outs", {addrWe, srWe, dmWe, misoBufe}, 0);
        resetN = 1'b1;
        idle(1);
        chk("rst_release_busy", busy, 1);
        end_frame();
        chk("rst_cs_idle", busy, 0);

        // Write frame
        a0 = n_addr; s0 = n_sr; d0 = n_dm;
        chipSelect = 1'b0; rwBit = 1'b0;
        idle(1);
        chk("wr_busy", busy, 1);
        pos_edges(7);
        idle(4);
        chk("wr_no_early_addr", addrWe, 0);
        pulse(1'b1, 1'b0);
        chk("wr_addrWe", addrWe, 1);
        idle(1);
        chk("wr_addrWe_1clk", addrWe, 0);
        chk("wr_no_srWe", srWe, 0);
        pos_edges(8);
        chk("wr_dmWe", dmWe, 1);
        idle(1);
        chk("wr_dmWe_1clk", dmWe, 0);
        chk("wr_done_busy", busy, 1);
        chk("wr_done_miso", misoBufe, 0);
        end_frame();
        chk("wr_idle_busy", busy, 0);
        chk("wr_addr_cnt", n_addr - a0, 1);
        chk("wr_dm_cnt", n_dm - d0, 1);
        chk("wr_sr_cnt", n_sr - s0, 0);

        // Read frame
        a0 = n_addr; s0 = n_sr; d0 = n_dm;
        chipSelect = 1'b0; rwBit = 1'b1;
        idle(1);
        pos_edges(8);
        chk("rd_addrWe", addrWe, 1);
        chk("rd_addr_miso0", misoBufe, 0);
        idle(1);
        chk("rd_srWe", srWe, 1);
        chk("rd_load_miso", misoBufe, 1);
        idle(1);
        chk("rd_srWe_1clk", srWe, 0);
        chk("rd_shift_miso", misoBufe, 1);
        pos_edges(2);
        neg_edges(7);
        chk("rd_shift7_miso", misoBufe, 1);
        idle(4);
        pulse(1'b0, 1'b1);
        chk("rd_done_miso", misoBufe, 0);
        chk("rd_done_busy", busy, 1);
        end_frame();
        chk("rd_addr_cnt", n_addr - a0, 1);
        chk("rd_sr_cnt", n_sr - s0, 1);
        chk("rd_dm_cnt", n_dm - d0, 0);

        // Abort after 5 data edges, then a clean write frame
        d0 = n_dm;
        chipSelect = 1'b0; rwBit = 1'b0;
        idle(1);
        pos_edges(8);
        idle(1);
        pos_edges(5);
        chipSelect = 1'b1;
        idle(1);
        chk("abort_idle", busy, 0);
        pos_edges(3);
        idle(1);
        chk("abort_no_dmWe", n_dm - d0, 0);
        chipSelect = 1'b0;
        idle(1);
        pos_edges(16);
        idle(2);
        chk("abort_new_dm_cnt", n_dm - d0, 1);
        end_frame();

        // Reset in READ_SHIFT, then a fresh address count
        a0 = n_addr;
        chipSelect = 1'b0; rwBit = 1'b1;
        idle(1);
        pos_edges(8);
        idle(2);
        neg_edges(3);
        resetN = 1'b0;
        idle(1);
        chk("mrst_miso", misoBufe, 0);
        chk("mrst_busy", busy, 0);
        resetN = 1'b1;
        idle(1);
        chk("mrst_restart_busy", busy, 1);
        pos_edges(7);
        idle(2);
        chk("mrst_no_addr_at7", n_addr - a0, 1);
        pulse(1'b1, 1'b0);
        chk("mrst_addrWe_at8", addrWe, 1);
        end_frame();

        // Simultaneous and stray edges in GET_ADDR, extra edges in DONE
        a0 = n_addr; d0 = n_dm; s0 = n_sr;
        chipSelect = 1'b0; rwBit = 1'b0;
        idle(1);
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, 1'b1);
            idle(2);
        end
        neg_edges(2);
        idle(2);
        pos_edges(4);
        idle(2);
        chk("ign_no_addr_at7", n_addr - a0, 0);
        pulse(1'b1, 1'b0);
        chk("ign_addrWe_at8", addrWe, 1);
        idle(1);
        pos_edges(8);
        chk("ign_dmWe", dmWe, 1);
        idle(1);
        pos_edges(3);
        neg_edges(2);
        idle(2);
        chk("ign_done_busy", busy, 1);
        chk("ign_addr_cnt", n_addr - a0, 1);
        chk("ign_dm_cnt", n_dm - d0, 1);
        chk("ign_sr_cnt", n_sr - s0, 0);
        end_frame();
        chk("one_hot_pulses", n_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
